ahb_lite_master: RTL and testbench

- Single-transfer AHB-Lite bus master, directly upstream of amba_ahb_slave.
- Converts a simple valid/ready command stream into pipelined AHB-Lite NONSEQ transfers on the ifa bus signals.
- Returns one response per command (read data and error flag), in order.
- Replaces hand-driven bus tasks in the test bench as the stimulus source, and is reusable as the RTL master.

---
 rtl/ahb_lite_pkg.sv | 29 ++
 rtl/ahb_lite_master_perf.sv | 47 ++++
 rtl/ahb_lite_master.sv | 162 ++++++++++++++++
 tb/tb_ahb_lite_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the master command record.
// Used by ahb_lite_master and its optional perf sub-module.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [CMD_DATA_W-1:0] wdata;
  } ahb_cmd_t;

endpackage

// File: rtl/ahb_lite_master_perf.sv
// Saturating transfer / wait-state / error counters for ahb_lite_master.
// Only instantiated when AHB_LITE_MASTER_PERF_EN is defined.
module ahb_lite_master_perf
  import ahb_lite_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              xfer_done,
  input  logic              wait_cycle,
  input  logic              err_pulse,
  output logic [PERF_W-1:0] perf_xfers,
  output logic [PERF_W-1:0] perf_waits,
  output logic [PERF_W-1:0] perf_errs
);

  logic [PERF_W-1:0] xfers_q, xfers_d;
  logic [PERF_W-1:0] waits_q, waits_d;
  logic [PERF_W-1:0] errs_q,  errs_d;

  always_comb begin
    xfers_d = xfers_q;
    waits_d = waits_q;
    errs_d  = errs_q;
    if (xfer_done  && (xfers_q != '1)) xfers_d = xfers_q + 1'b1;
    if (wait_cycle && (waits_q != '1)) waits_d = waits_q + 1'b1;
    if (err_pulse  && (errs_q  != '1)) errs_d  = errs_q  + 1'b1;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      xfers_q <= '0;
      waits_q <= '0;
      errs_q  <= '0;
    end else begin
      xfers_q <= xfers_d;
      waits_q <= waits_d;
      errs_q  <= errs_d;
    end
  end

  assign perf_xfers = xfers_q;
  assign perf_waits = waits_q;
  assign perf_errs  = errs_q;

endmodule

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite master: valid/ready commands in, pipelined NONSEQ out.
// Define AHB_LITE_MASTER_PERF_EN to add the perf_xfers/perf_waits/perf_errs counters.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
`ifdef AHB_LITE_MASTER_PERF_EN
  ,
  parameter int         PERF_W    = 32
`endif
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hprot,
  output logic              hmastlock,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
`ifdef AHB_LITE_MASTER_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_xfers,
  output logic [PERF_W-1:0] perf_waits,
  output logic [PERF_W-1:0] perf_errs
`endif
);

  logic              ap_valid_q, ap_valid_d;
  logic              ap_write_q, ap_write_d;
  logic [ADDR_W-1:0] ap_addr_q,  ap_addr_d;
  logic [2:0]        ap_size_q,  ap_size_d;
  logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
  logic              ep_q,       ep_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  logic dp_err_first;
  logic accept;
  logic retire;

  // First ERROR cycle: block new commands so the cancelled AP is not overwritten.
  assign dp_err_first = dp_valid_q && !hready && (hresp == HRESP_ERROR);
  assign cmd_ready    = !hreset && !ep_q && !dp_err_first && (!ap_valid_q || hready);
  assign accept       = cmd_valid && cmd_ready;
  assign retire       = dp_valid_q && hready;

  always_comb begin
    ap_valid_d  = ap_valid_q;
    ap_write_d  = ap_write_q;
    ap_addr_d   = ap_addr_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    ep_d        = ep_q;
    rsp_valid_d = retire;
    rsp_err_d   = retire && (hresp == HRESP_ERROR);
    rsp_rdata_d = (retire && !dp_write_q) ? hrdata : '0;

    if (hready) begin
      if (ep_q) begin
        // AP was driven as IDLE this cycle, so it stays put and is re-issued next.
        dp_valid_d = 1'b0;
        ep_d       = 1'b0;
      end else begin
        dp_valid_d = ap_valid_q;
        dp_write_d = ap_write_q;
        dp_wdata_d = ap_wdata_q;
        ap_valid_d = 1'b0;
      end
    end else if (dp_err_first) begin
      ep_d = 1'b1;
    end

    if (accept) begin
      ap_valid_d = 1'b1;
      ap_write_d = cmd_write;
      ap_addr_d  = cmd_addr;
      ap_size_d  = cmd_size;
      ap_wdata_d = cmd_wdata;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      ap_valid_q  <= 1'b0;
      ap_write_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_size_q   <= '0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      ep_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ap_valid_q  <= ap_valid_d;
      ap_write_q  <= ap_write_d;
      ap_addr_q   <= ap_addr_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      ep_q        <= ep_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign haddr     = ap_addr_q;
  assign hwrite    = ap_write_q;
  assign hsize     = ap_size_q;
  assign htrans    = (ap_valid_q && !ep_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;
  assign hwdata    = dp_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef AHB_LITE_MASTER_PERF_EN
  ahb_lite_master_perf #(
    .PERF_W(PERF_W)
  ) u_perf (
    .hclk      (hclk),
    .hreset    (hreset),
    .xfer_done (retire),
    .wait_cycle(dp_valid_q && !hready),
    .err_pulse (rsp_valid_q && rsp_err_q),
    .perf_xfers(perf_xfers),
    .perf_waits(perf_waits),
    .perf_errs (perf_errs)
  );
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master; the bench plays the slave
// by driving hready/hresp/hrdata cycle by cycle.
module tb_ahb_lite_master;

  logic        hclk;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
`ifdef AHB_LITE_MASTER_PERF_EN
  logic [31:0] perf_xfers;
  logic [31:0] perf_waits;
  logic [31:0] perf_errs;
`endif

  int checks = 0;
  int passes = 0;

  ahb_lite_master dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
`ifdef AHB_LITE_MASTER_PERF_EN
    , .perf_xfers(perf_xfers), .perf_waits(perf_waits), .perf_errs(perf_errs)
`endif
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_cmd(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    set_cmd(1'b1, 32'h100, 3'd2, 32'h1111_2222);
    step(); step(); step();
    checks++; if (htrans !== 2'b00) $display("FAIL reset_htrans: got %h expected 0", htrans); else passes++;
    checks++; if (haddr !== 32'h0) $display("FAIL reset_haddr: got %h expected 0", haddr); else passes++;
    checks++; if ({hwrite, hsize} !== 4'h0) $display("FAIL reset_hwrite_hsize: got %h expected 0", {hwrite, hsize}); else passes++;
    checks++; if (hwdata !== 32'h0) $display("FAIL reset_hwdata: got %h expected 0", hwdata); else passes++;
    checks++; if ({rsp_valid, rsp_err} !== 2'b00) $display("FAIL reset_rsp: got %b expected 00", {rsp_valid, rsp_err}); else passes++;
    checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); else passes++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); else passes++;
    cmd_valid = 1'b0;
    hreset    = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    hrdata = 32'hDEAD_BEEF;
    set_cmd(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL wr_cmd_ready: got %b expected 1", cmd_ready); else passes++;
    step();
    set_cmd(1'b0, 32'h10, 3'd2, 32'h0);
    #1;
    checks++; if (htrans !== 2'b10) $display("FAIL wr_ap_htrans: got %h expected 2", htrans); else passes++;
    checks++; if ({haddr, hwrite} !== {32'h10, 1'b1}) $display("FAIL wr_ap_addr: got %h/%b expected 10/1", haddr, hwrite); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rd_cmd_ready: got %b expected 1", cmd_ready); else passes++;
    step();
    cmd_valid = 1'b0;
    #1;
    checks++; if ({htrans, hwrite} !== {2'b10, 1'b0}) $display("FAIL rd_ap: got %h/%b expected 2/0", htrans, hwrite); else passes++;
    checks++; if (hwdata !== 32'hDEAD_BEEF) $display("FAIL wr_hwdata: got %h expected deadbeef", hwdata); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_early: got %b expected 0", rsp_valid); else passes++;
    step();
    checks++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL wr_rsp: got %b expected 10", {rsp_valid, rsp_err}); else passes++;
    checks++; if (rsp_rdata !== 32'h0) $display("FAIL wr_rsp_rdata: got %h expected 0", rsp_rdata); else passes++;
    checks++; if (htrans !== 2'b00) $display("FAIL wr_rd_idle: got %h expected 0", htrans); else passes++;
    step();
    checks++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL rd_rsp: got %b expected 10", {rsp_valid, rsp_err}); else passes++;
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rsp_rdata: got %h expected deadbeef", rsp_rdata); else passes++;
    step();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rd_rsp_single: got %b expected 0", rsp_valid); else passes++;
  endtask

  task automatic test_back_to_back();
    int rsp_cnt = 0;
    for (int j = 0; j < 7; j++) begin
      if (j < 4) begin
        set_cmd(1'b1, 32'(4 * j), 3'd2, 32'hA000_0000 + 32'(j));
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_cmd_ready[%0d]: got %b expected 1", j, cmd_ready); else passes++;
      end else begin
        cmd_valid = 1'b0;
      end
      step();
      checks++;
      if (htrans !== ((j < 4) ? 2'b10 : 2'b00)) $display("FAIL b2b_htrans[%0d]: got %h expected %h", j, htrans, (j < 4) ? 2'b10 : 2'b00);
      else passes++;
      if (j < 4) begin
        checks++; if (haddr !== 32'(4 * j)) $display("FAIL b2b_haddr[%0d]: got %h expected %h", j, haddr, 4 * j); else passes++;
      end
      checks++;
      if (rsp_valid !== (j >= 2 && j < 6)) $display("FAIL b2b_rsp_valid[%0d]: got %b expected %b", j, rsp_valid, (j >= 2 && j < 6));
      else passes++;
      if (rsp_valid) rsp_cnt++;
    end
    checks++; if (rsp_cnt != 4) $display("FAIL b2b_rsp_count: got %0d expected 4", rsp_cnt); else passes++;
  endtask

  task automatic test_wait_states();
`ifdef AHB_LITE_MASTER_PERF_EN
    logic [31:0] waits0;
    waits0 = perf_waits;
`endif
    set_cmd(1'b0, 32'h20, 3'd2, 32'h55AA_55AA);
    step();
    set_cmd(1'b0, 32'h24, 3'd2, 32'h0);
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hready = 1'b0;
      #1;
      checks++; if ({htrans, haddr} !== {2'b10, 32'h24}) $display("FAIL wait_addr_hold[%0d]: got %h/%h expected 2/24", k, htrans, haddr); else passes++;
      checks++; if (hwdata !== 32'h55AA_55AA) $display("FAIL wait_hwdata[%0d]: got %h expected 55aa55aa", k, hwdata); else passes++;
      checks++; if ({cmd_ready, rsp_valid} !== 2'b00) $display("FAIL wait_ready_rsp[%0d]: got %b expected 00", k, {cmd_ready, rsp_valid}); else passes++;
      step();
    end
    hready = 1'b1;
    hrdata = 32'h1234_5678;
    step();
    checks++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL wait_rsp: got %b expected 10", {rsp_valid, rsp_err}); else passes++;
    checks++; if (rsp_rdata !== 32'h1234_5678) $display("FAIL wait_rsp_rdata: got %h expected 12345678", rsp_rdata); else passes++;
    hrdata = 32'hCAFE_F00D;
    step();
    checks++; if (rsp_rdata !== 32'hCAFE_F00D) $display("FAIL wait_next_rdata: got %h expected cafef00d", rsp_rdata); else passes++;
`ifdef AHB_LITE_MASTER_PERF_EN
    checks++; if (perf_waits - waits0 !== 32'd3) $display("FAIL perf_waits: got %0d expected 3", perf_waits - waits0); else passes++;
`endif
    step();
  endtask

  task automatic test_error();
    set_cmd(1'b1, 32'h40, 3'd2, 32'h4040_4040);
    step();
    set_cmd(1'b0, 32'h44, 3'd2, 32'h0);
    step();
    cmd_valid = 1'b0;
    hready    = 1'b0;
    hresp     = 1'b1;
    #1;
    checks++; if ({htrans, haddr} !== {2'b10, 32'h44}) $display("FAIL err_c1_ap: got %h/%h expected 2/44", htrans, haddr); else passes++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL err_c1_cmd_ready: got %b expected 0", cmd_ready); else passes++;
    step();
    hready = 1'b1;
    #1;
    checks++; if (htrans !== 2'b00) $display("FAIL err_c2_idle: got %h expected 0", htrans); else passes++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL err_c2_cmd_ready: got %b expected 0", cmd_ready); else passes++;
    step();
    hresp  = 1'b0;
    hrdata = 32'h4444_4444;
    checks++; if ({rsp_valid, rsp_err} !== 2'b11) $display("FAIL err_rsp: got %b expected 11", {rsp_valid, rsp_err}); else passes++;
    checks++; if ({htrans, haddr, hwrite} !== {2'b10, 32'h44, 1'b0}) $display("FAIL err_reissue: got %h/%h/%b expected 2/44/0", htrans, haddr, hwrite); else passes++;
    step();
    checks++; if ({rsp_valid, htrans} !== 3'b000) $display("FAIL err_gap: got %b expected 000", {rsp_valid, htrans}); else passes++;
    step();
    checks++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL err_next_rsp: got %b expected 10", {rsp_valid, rsp_err}); else passes++;
    checks++; if (rsp_rdata !== 32'h4444_4444) $display("FAIL err_next_rdata: got %h expected 44444444", rsp_rdata); else passes++;
    step();
  endtask

  task automatic test_reset_midflight();
    set_cmd(1'b0, 32'h30, 3'd2, 32'h0);
    step();
    cmd_valid = 1'b0;
    step();
    hready = 1'b0;
    step();
    hreset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); else passes++;
    step();
    hreset = 1'b0;
    hready = 1'b1;
    checks++; if ({htrans, rsp_valid} !== 3'b000) $display("FAIL rst_idle: got %b expected 000", {htrans, rsp_valid}); else passes++;
    step();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_no_rsp: got %b expected 0", rsp_valid); else passes++;
    hrdata = 32'h0BAD_F00D;
    set_cmd(1'b0, 32'h10, 3'd2, 32'h0);
    step();
    cmd_valid = 1'b0;
    checks++; if ({htrans, haddr} !== {2'b10, 32'h10}) $display("FAIL rst_new_ap: got %h/%h expected 2/10", htrans, haddr); else passes++;
    step();
    step();
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0BAD_F00D}) $display("FAIL rst_new_rsp: got %b/%h expected 10/0badf00d", {rsp_valid, rsp_err}, rsp_rdata); else passes++;
    step();
  endtask

  task automatic test_byte_write();
    set_cmd(1'b1, 32'h13, 3'd0, 32'h0000_00AB);
    step();
    cmd_valid = 1'b0;
    checks++; if ({htrans, haddr, hwrite, hsize} !== {2'b10, 32'h13, 1'b1, 3'd0}) $display("FAIL byte_ap: got %h/%h/%b/%h expected 2/13/1/0", htrans, haddr, hwrite, hsize); else passes++;
    checks++; if ({hburst, hprot, hmastlock} !== {3'b000, 4'b0011, 1'b0}) $display("FAIL byte_const: got %h/%h/%b expected 0/3/0", hburst, hprot, hmastlock); else passes++;
    step();
    checks++; if (hwdata !== 32'h0000_00AB) $display("FAIL byte_hwdata: got %h expected ab", hwdata); else passes++;
    step();
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) $display("FAIL byte_rsp: got %b/%h expected 10/0", {rsp_valid, rsp_err}, rsp_rdata); else passes++;
    step();
  endtask

  initial begin
    hreset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_size  = 3'd0;
    cmd_wdata = 32'h0;
    hrdata    = 32'h0;
    hready    = 1'b1;
    hresp     = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_midflight();
    test_byte_write();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
